tangconsole_led_arbiter: RTL and testbench

Shares the board's two status LEDs (`led[0]` DONE pin, `led[1]` READY pin) between several internal status sources. Each requester asks for the LEDs with a 2-bit-per-LED display mode. A fixed-priority arbiter with a minimum hold time grants one owner. A built-in prescaler/phase counter renders steady and blinking patterns. The block sits between the status sources of the tangconsole top level and the LED pins, replacing free-running blink logic.

---
 rtl/tangconsole_led_pkg.sv | 29 ++
 rtl/tangconsole_led_tick.sv | 33 +++
 rtl/tangconsole_led_arbiter.sv | 111 +++++++++++
 tb/tb_tangconsole_led_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tangconsole_led_pkg.sv
// Shared constants, state encoding and the per-LED render helper for the LED arbiter.
package tangconsole_led_pkg;

    localparam logic [1:0] LED_OFF  = 2'b00;
    localparam logic [1:0] LED_ON   = 2'b01;
    localparam logic [1:0] LED_SLOW = 2'b10;
    localparam logic [1:0] LED_FAST = 2'b11;

    localparam int PHASE_SLOW_BIT = 3;
    localparam int PHASE_FAST_BIT = 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    // Drive level of one LED for a 2-bit display mode at the given blink phase.
    function automatic logic led_render(input logic [1:0] led_mode, input logic [3:0] phase);
        logic lvl;
        case (led_mode)
            LED_ON:   lvl = 1'b1;
            LED_SLOW: lvl = phase[PHASE_SLOW_BIT];
            LED_FAST: lvl = phase[PHASE_FAST_BIT];
            default:  lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/tangconsole_led_tick.sv
// Prescaler producing a one-cycle tick every TICK_DIV cycles, plus a 4-bit blink phase.
module tangconsole_led_tick #(
    parameter int TICK_DIV = 2_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       tick,
    output logic [3:0] phase
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] tick_cnt_q;
    logic [3:0]       phase_q;

    assign tick  = (tick_cnt_q == CNT_LAST);
    assign phase = phase_q;

    // Wrap the prescaler at TICK_DIV-1 and advance the phase on each tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            phase_q    <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
            phase_q    <= phase_q + 4'd1;
        end else begin
            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tangconsole_led_arbiter.sv
// Fixed-priority owner arbitration with minimum hold time for the two board status LEDs.
// The owner's live mode bits and the blink phase are rendered into a registered LED drive.
module tangconsole_led_arbiter
    import tangconsole_led_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TICK_DIV   = 2_000_000,
    parameter int HOLD_TICKS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] mode,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tick,
    output logic [1:0]           led
);

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_TICKS);

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [3:0]         hold_q;
    logic [1:0]         led_q;
    logic [1:0]         led_d;
    logic [3:0]         phase;
    logic [3:0]         owner_mode;
    logic [NUM_REQ-1:0] req_first;
    logic [NUM_REQ-1:0] hi_req;
    logic [NUM_REQ-1:0] hi_first;

    tangconsole_led_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .phase   (phase)
    );

    // Lowest set bit picks the winner; grant_q-1 masks indices above the (one-hot) owner.
    assign req_first = req & (~req + NUM_REQ'(1));
    assign hi_req    = req & (grant_q - NUM_REQ'(1));
    assign hi_first  = hi_req & (~hi_req + NUM_REQ'(1));

    // Arbiter FSM: grant, release, and preemption once the hold time has run out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        state_q <= S_OWN;
                        grant_q <= req_first;
                        hold_q  <= HOLD_INIT;
                    end
                end
                S_OWN: begin
                    if ((req & grant_q) == '0) begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                        hold_q  <= '0;
                    end else if (hold_q != 4'd0) begin
                        if (tick) begin
                            hold_q <= hold_q - 4'd1;
                        end
                    end else if (|hi_req) begin
                        grant_q <= hi_first;
                        hold_q  <= HOLD_INIT;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    // Select the current owner's mode nibble from the one-hot grant.
    always_comb begin
        owner_mode = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_mode = owner_mode | mode[4*i +: 4];
            end
        end
        if (state_q == S_OWN) begin
            led_d = {led_render(owner_mode[3:2], phase), led_render(owner_mode[1:0], phase)};
        end else begin
            led_d = 2'b00;
        end
    end

    // Register the LED drive so the pins see a clean, glitch-free level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q <= 2'b00;
        end else begin
            led_q <= led_d;
        end
    end

    assign grant = grant_q;
    assign led   = led_q;

endmodule

// File: tb/tb_tangconsole_led_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requests, checked every cycle
// against an integer-level reference model of the arbiter, prescaler and LED rendering.
module tb_tangconsole_led_arbiter;

    localparam int NR = 4;
    localparam int TD = 4;
    localparam int HT = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [4*NR-1:0] mode = '0;
    logic [NR-1:0] grant;
    logic          tick;
    logic [1:0]    led;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int       m_n;
    int       m_owner;
    int       m_hold;
    logic [1:0] m_led;

    tangconsole_led_arbiter #(
        .NUM_REQ    (NR),
        .TICK_DIV   (TD),
        .HOLD_TICKS (HT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .mode    (mode),
        .grant   (grant),
        .tick    (tick),
        .led     (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic render(input logic [1:0] md, input int ph);
        case (md)
            2'd1:    return 1'b1;
            2'd2:    return 1'((ph >> 3) & 1);
            2'd3:    return 1'((ph >> 1) & 1);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] exp_grant();
        if (m_owner < 0) return 32'd0;
        return 32'd1 << m_owner;
    endfunction

    task automatic model_reset();
        m_n     = 0;
        m_owner = -1;
        m_hold  = 0;
        m_led   = 2'b00;
    endtask

    // Advance the model by one clock edge using the inputs present before the edge.
    task automatic model_update();
        int ph;
        int nw;
        bit tk;
        ph = (m_n / TD) % 16;
        tk = ((m_n % TD) == TD - 1);
        if (m_owner < 0) begin
            m_led = 2'b00;
            if (req != 0) begin
                nw = -1;
                for (int j = NR - 1; j >= 0; j--) if (req[j]) nw = j;
                m_owner = nw;
                m_hold  = HT;
            end
        end else begin
            m_led = {render(mode[4*m_owner+2 +: 2], ph), render(mode[4*m_owner +: 2], ph)};
            if (!req[m_owner]) begin
                m_owner = -1;
            end else if (m_hold > 0) begin
                if (tk) m_hold--;
            end else begin
                nw = -1;
                for (int j = m_owner - 1; j >= 0; j--) if (req[j]) nw = j;
                if (nw >= 0) begin
                    m_owner = nw;
                    m_hold  = HT;
                end
            end
        end
        m_n++;
    endtask

    // Entered and left at a falling edge: check outputs, apply inputs, cross one rising edge.
    task automatic step(input logic [NR-1:0] r, input logic [4*NR-1:0] m);
        chk("grant", 32'(grant), exp_grant());
        chk("led", 32'(led), 32'(m_led));
        chk("tick", 32'(tick), 32'((m_n % TD) == TD - 1));
        req  = r;
        mode = m;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Asynchronous reset between edges; outputs must clear before the next rising edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [NR-1:0]   r;
        logic [4*NR-1:0] m;

        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // idle prescaler
        repeat (16) step('0, '0);
        // basic grant and release
        repeat (3) step(4'b0100, 16'h0100);
        repeat (3) step(4'b0000, 16'h0100);
        // hold blocks preemption, then higher priority takes over
        step(4'b0100, 16'h0300);
        repeat (14) step(4'b0101, 16'h0302);
        repeat (2) step('0, '0);
        // lower priority never preempts, then blink rates
        repeat (2) step(4'b0001, 16'h000E);
        repeat (40) step(4'b1001, 16'h200E);
        repeat (80) step(4'b0001, 16'h000E);
        // reset mid-blink
        chk("led_before_rst_owner", 32'(grant), 32'd1);
        do_reset();
        // simultaneous release and higher-priority request
        repeat (4) step(4'b0100, 16'h0D00);
        repeat (4) step(4'b0001, 16'h0D07);

        // randomized requests and occasional live mode changes
        r = '0;
        m = 16'($urandom);
        repeat (3000) begin
            for (int b = 0; b < NR; b++) if ($urandom_range(15) == 0) r[b] = ~r[b];
            if ($urandom_range(31) == 0) m = 16'($urandom);
            step(r, m);
        end
        do_reset();
        repeat (500) begin
            for (int b = 0; b < NR; b++) if ($urandom_range(7) == 0) r[b] = ~r[b];
            if ($urandom_range(15) == 0) m = 16'($urandom);
            step(r, m);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
